// File: rtl/mem_axi_bridge_pkg.sv
// rtl/mem_axi_bridge_pkg.sv - shared encodings and AXI constants for mem_axi_bridge
package mem_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_AR  = 3'd1,
    ST_RD_R   = 3'd2,
    ST_WR_AWW = 3'd3,
    ST_WR_B   = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    TAG_INST   = 2'd0,
    TAG_DREAD  = 2'd1,
    TAG_DWRITE = 2'd2
  } tag_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int INST_ID_DEF = 0;
  localparam int DATA_ID_DEF = 1;

  // SLVERR (2'b10) and DECERR (2'b11) both have the upper bit set
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/mem_axi_bridge.sv
// rtl/mem_axi_bridge.sv - SRAM-style request port to single-beat AXI bridge (optional MEM_AXI_BUS_ERR_EN)
module mem_axi_bridge
  import mem_axi_bridge_pkg::*;
#(
  parameter int ID_W    = 4,
  parameter int INST_ID = INST_ID_DEF,
  parameter int DATA_ID = DATA_ID_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_ren,
  input  logic [31:0]     inst_addr,
  output logic            inst_ok,
  output logic [31:0]     inst_rdata,
  input  logic            data_ren,
  input  logic [3:0]      data_wen,
  input  logic [31:0]     data_addr,
  input  logic [31:0]     data_wdata,
  output logic            data_read_ok,
  output logic            data_write_ok,
  output logic [31:0]     data_rdata,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic            arvalid,
  input  logic            arready,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [1:0]      arlock,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic            awvalid,
  input  logic            awready,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic [1:0]      awlock,
  output logic [3:0]      awcache,
  output logic [2:0]      awprot,
  output logic [ID_W-1:0] wid,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
`ifdef MEM_AXI_BUS_ERR_EN
  output logic            bus_err,
  output logic [31:0]     bus_err_addr,
`endif
  output logic            bready
);

  state_t      r_state;
  state_t      w_next;
  tag_t        r_tag;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic        r_aw_done;
  logic        r_w_done;

  logic w_req;
  logic w_aw_all;
  logic w_w_all;

  assign w_req    = (data_wen != 4'd0) | data_ren | inst_ren;
  // A channel counts as done if it finished earlier or handshakes this cycle
  assign w_aw_all = r_aw_done | (awvalid & awready);
  assign w_w_all  = r_w_done | (wvalid & wready);

  assign arid    = (r_tag == TAG_INST) ? ID_W'(INST_ID) : ID_W'(DATA_ID);
  assign araddr  = r_addr;
  assign awid    = ID_W'(DATA_ID);
  assign awaddr  = r_addr;
  assign wid     = ID_W'(DATA_ID);
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = 1'b1;
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arsize  = SIZE_WORD;
  assign awsize  = SIZE_WORD;
  assign arburst = BURST_INCR;
  assign awburst = BURST_INCR;
  assign arlock  = 2'd0;
  assign awlock  = 2'd0;
  assign arcache = 4'd0;
  assign awcache = 4'd0;
  assign arprot  = 3'd0;
  assign awprot  = 3'd0;

  assign inst_rdata = r_rdata;
  assign data_rdata = r_rdata;

  // IDs, rlast and (in the base build) response codes carry no information we act on
`ifdef MEM_AXI_BUS_ERR_EN
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, rid, rlast, bid};
`else
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, rid, rlast, bid, rresp, bresp, RESP_OKAY};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; writes win over reads, data over instruction
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (data_wen != 4'd0)         w_next = ST_WR_AWW;
        else if (data_ren | inst_ren) w_next = ST_RD_AR;
      end
      ST_RD_AR:  if (arready)              w_next = ST_RD_R;
      ST_RD_R:   if (rvalid)               w_next = ST_RESP;
      ST_WR_AWW: if (w_aw_all && w_w_all)  w_next = ST_WR_B;
      ST_WR_B:   if (bvalid)               w_next = ST_RESP;
      ST_RESP:                             w_next = ST_IDLE;
      default:                             w_next = ST_IDLE;
    endcase
  end

  // Channel valids/readies and the one-cycle ok pulses
  always_comb begin
    arvalid       = 1'b0;
    rready        = 1'b0;
    awvalid       = 1'b0;
    wvalid        = 1'b0;
    bready        = 1'b0;
    inst_ok       = 1'b0;
    data_read_ok  = 1'b0;
    data_write_ok = 1'b0;
    case (r_state)
      ST_RD_AR:  arvalid = 1'b1;
      ST_RD_R:   rready  = 1'b1;
      ST_WR_AWW: begin
        awvalid = ~r_aw_done;
        wvalid  = ~r_w_done;
      end
      ST_WR_B:   bready  = 1'b1;
      ST_RESP: begin
        inst_ok       = (r_tag == TAG_INST);
        data_read_ok  = (r_tag == TAG_DREAD);
        data_write_ok = (r_tag == TAG_DWRITE);
      end
      default: ;
    endcase
  end

  // Request capture, per-channel done flags and read-data latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag     <= TAG_INST;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_wstrb   <= 4'd0;
      r_rdata   <= 32'd0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_wdata   <= data_wdata;
            r_wstrb   <= data_wen;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (data_wen != 4'd0) begin
              r_tag  <= TAG_DWRITE;
              r_addr <= data_addr;
            end else if (data_ren) begin
              r_tag  <= TAG_DREAD;
              r_addr <= data_addr;
            end else begin
              r_tag  <= TAG_INST;
              r_addr <= inst_addr;
            end
          end
        end
        ST_WR_AWW: begin
          if (awvalid && awready) r_aw_done <= 1'b1;
          if (wvalid && wready)   r_w_done  <= 1'b1;
        end
        ST_RD_R: if (rvalid) r_rdata <= rdata;
        default: ;
      endcase
    end
  end

`ifdef MEM_AXI_BUS_ERR_EN
  // Sticky error flag with the address of the first-seen failing response
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err      <= 1'b0;
      bus_err_addr <= 32'd0;
    end else if (((r_state == ST_RD_R) && rvalid && resp_is_err(rresp)) ||
                 ((r_state == ST_WR_B) && bvalid && resp_is_err(bresp))) begin
      bus_err      <= 1'b1;
      bus_err_addr <= r_addr;
    end
  end
`endif

endmodule

// File: tb/tb_mem_axi_bridge.sv
// tb/tb_mem_axi_bridge.sv - directed self-checking bench for mem_axi_bridge
module tb_mem_axi_bridge;

  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            inst_ren;
  logic [31:0]     inst_addr;
  logic            inst_ok;
  logic [31:0]     inst_rdata;
  logic            data_ren;
  logic [3:0]      data_wen;
  logic [31:0]     data_addr;
  logic [31:0]     data_wdata;
  logic            data_read_ok;
  logic            data_write_ok;
  logic [31:0]     data_rdata;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic            arvalid;
  logic            arready;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [1:0]      arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic            awvalid;
  logic            awready;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [1:0]      awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
`ifdef MEM_AXI_BUS_ERR_EN
  logic            bus_err;
  logic [31:0]     bus_err_addr;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_axi_bridge #(.ID_W(ID_W), .INST_ID(0), .DATA_ID(1)) dut (
    .clk(clk), .rst(rst),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_ok(inst_ok), .inst_rdata(inst_rdata),
    .data_ren(data_ren), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_read_ok(data_read_ok), .data_write_ok(data_write_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid),
`ifdef MEM_AXI_BUS_ERR_EN
    .bus_err(bus_err), .bus_err_addr(bus_err_addr),
`endif
    .bready(bready)
  );

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_chk++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %b want 0", arvalid); end
    n_chk++; if ({awvalid, wvalid, rready, bready} !== 4'b0) begin n_fail++; $display("FAIL rst_handshake: got %b want 0000", {awvalid, wvalid, rready, bready}); end
    n_chk++; if ({inst_ok, data_read_ok, data_write_ok} !== 3'b0) begin n_fail++; $display("FAIL rst_ok: got %b want 000", {inst_ok, data_read_ok, data_write_ok}); end
    n_chk++; if ({araddr, wdata} !== 64'd0) begin n_fail++; $display("FAIL rst_regs: got %h want 0", {araddr, wdata}); end
    n_chk++; if (wstrb !== 4'd0) begin n_fail++; $display("FAIL rst_wstrb: got %h want 0", wstrb); end
    n_chk++; if (wlast !== 1'b1) begin n_fail++; $display("FAIL rst_wlast: got %b want 1", wlast); end
    n_chk++; if ({arlen, arsize, arburst} !== {8'd0, 3'd2, 2'b01}) begin n_fail++; $display("FAIL rst_arconst: got %h want %h", {arlen, arsize, arburst}, {8'd0, 3'd2, 2'b01}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_inst_read();
    inst_ren = 1'b1; inst_addr = 32'h1FC0_0000;
    tick(); // cycle 1
    inst_ren = 1'b0; arready = 1'b1;
    n_chk++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL ir_arvalid: got %b want 1", arvalid); end
    n_chk++; if (araddr !== 32'h1FC0_0000) begin n_fail++; $display("FAIL ir_araddr: got %h want 1fc00000", araddr); end
    n_chk++; if (arid !== 4'd0) begin n_fail++; $display("FAIL ir_arid: got %0d want 0", arid); end
    tick(); // cycle 2
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h3C08_BFC0;
    n_chk++; if ({arvalid, rready} !== 2'b01) begin n_fail++; $display("FAIL ir_rready: got %b want 01", {arvalid, rready}); end
    n_chk++; if (inst_ok !== 1'b0) begin n_fail++; $display("FAIL ir_ok_early: got %b want 0", inst_ok); end
    tick(); // cycle 3
    rvalid = 1'b0; rdata = 32'h0;
    n_chk++; if (inst_ok !== 1'b1) begin n_fail++; $display("FAIL ir_ok: got %b want 1", inst_ok); end
    n_chk++; if (inst_rdata !== 32'h3C08_BFC0) begin n_fail++; $display("FAIL ir_rdata: got %h want 3c08bfc0", inst_rdata); end
    n_chk++; if ({rready, data_read_ok} !== 2'b00) begin n_fail++; $display("FAIL ir_resp_misc: got %b want 00", {rready, data_read_ok}); end
    tick(); // cycle 4
    n_chk++; if ({inst_ok, arvalid} !== 2'b00) begin n_fail++; $display("FAIL ir_ok_pulse: got %b want 00", {inst_ok, arvalid}); end
  endtask

  task automatic test_write_delayed_aw();
    int n_wok;
    data_wen = 4'b0011; data_addr = 32'h0000_1004; data_wdata = 32'hDEAD_BEEF;
    awready = 1'b0; wready = 1'b1;
    tick(); // cycle 1
    n_chk++; if ({awvalid, wvalid} !== 2'b11) begin n_fail++; $display("FAIL wr_valids_c1: got %b want 11", {awvalid, wvalid}); end
    n_chk++; if ({awaddr, wdata} !== {32'h0000_1004, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL wr_addr_data: got %h want 00001004deadbeef", {awaddr, wdata}); end
    n_chk++; if ({wstrb, awid, wlast} !== {4'b0011, 4'd1, 1'b1}) begin n_fail++; $display("FAIL wr_strb_id: got %h want %h", {wstrb, awid, wlast}, {4'b0011, 4'd1, 1'b1}); end
    tick(); // cycle 2
    wready = 1'b0;
    n_chk++; if ({awvalid, wvalid} !== 2'b10) begin n_fail++; $display("FAIL wr_valids_c2: got %b want 10", {awvalid, wvalid}); end
    tick(); // cycle 3
    n_chk++; if ({awvalid, wvalid, bready} !== 3'b100) begin n_fail++; $display("FAIL wr_valids_c3: got %b want 100", {awvalid, wvalid, bready}); end
    tick(); // cycle 4
    awready = 1'b1;
    n_chk++; if ({awvalid, wvalid} !== 2'b10) begin n_fail++; $display("FAIL wr_valids_c4: got %b want 10", {awvalid, wvalid}); end
    tick(); // cycle 5
    awready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
    n_chk++; if ({awvalid, wvalid, bready, data_write_ok} !== 4'b0010) begin n_fail++; $display("FAIL wr_b_state: got %b want 0010", {awvalid, wvalid, bready, data_write_ok}); end
    n_wok = 0;
    tick(); // cycle 6
    bvalid = 1'b0;
    n_chk++; if (data_write_ok !== 1'b1) begin n_fail++; $display("FAIL wr_ok: got %b want 1", data_write_ok); end
    for (int c = 6; c <= 11; c++) begin
      if (data_write_ok === 1'b1) n_wok++;
      if (c == 6) begin
        tick();
        data_wen = 4'b0000;
      end else begin
        if (awvalid !== 1'b0) n_wok += 100;
        tick();
      end
    end
    n_chk++; if (n_wok !== 1) begin n_fail++; $display("FAIL wr_single_ok: got %0d want 1", n_wok); end
  endtask

  task automatic test_priority();
    int n_ar;
    data_ren = 1'b1; inst_ren = 1'b1; data_addr = 32'h0000_2000; inst_addr = 32'h1FC0_0010;
    tick(); // cycle 1
    data_ren = 1'b0; inst_ren = 1'b0; arready = 1'b1;
    n_chk++; if ({arvalid, arid} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL pr_arid: got %h want 11", {arvalid, arid}); end
    n_chk++; if (araddr !== 32'h0000_2000) begin n_fail++; $display("FAIL pr_araddr: got %h want 00002000", araddr); end
    tick(); // cycle 2
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678;
    tick(); // cycle 3
    rvalid = 1'b0;
    n_chk++; if ({data_read_ok, inst_ok} !== 2'b10) begin n_fail++; $display("FAIL pr_ok: got %b want 10", {data_read_ok, inst_ok}); end
    n_chk++; if (data_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL pr_rdata: got %h want 12345678", data_rdata); end
    n_ar = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (arvalid !== 1'b0 || inst_ok !== 1'b0) n_ar++;
    end
    n_chk++; if (n_ar !== 0) begin n_fail++; $display("FAIL pr_no_inst: got %0d want 0", n_ar); end
  endtask

  task automatic test_ar_stall();
    int n_bad;
    inst_ren = 1'b1; inst_addr = 32'h1FC0_0100; arready = 1'b0;
    tick(); // cycle 1
    inst_ren = 1'b0; inst_addr = 32'h0;
    n_bad = 0;
    for (int c = 1; c <= 10; c++) begin
      if (arvalid !== 1'b1 || araddr !== 32'h1FC0_0100 || arid !== 4'd0 || inst_ok !== 1'b0) n_bad++;
      tick();
    end
    n_chk++; if (n_bad !== 0) begin n_fail++; $display("FAIL st_stable: got %0d bad cycles want 0", n_bad); end
    arready = 1'b1; // cycle 11
    n_chk++; if ({arvalid, araddr} !== {1'b1, 32'h1FC0_0100}) begin n_fail++; $display("FAIL st_c11: got %h want 11fc00100", {arvalid, araddr}); end
    tick(); // cycle 12
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    n_chk++; if ({inst_ok, rready, arvalid} !== 3'b010) begin n_fail++; $display("FAIL st_c12: got %b want 010", {inst_ok, rready, arvalid}); end
    tick(); // cycle 13
    rvalid = 1'b0;
    n_chk++; if ({inst_ok, inst_rdata} !== {1'b1, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL st_ok: got %h want 1cafef00d", {inst_ok, inst_rdata}); end
    tick();
  endtask

  task automatic test_reset_mid();
    inst_ren = 1'b1; inst_addr = 32'h1FC0_0200; arready = 1'b1;
    tick(); // cycle 1
    inst_ren = 1'b0;
    tick(); // cycle 2, RD_R
    arready = 1'b0;
    n_chk++; if (rready !== 1'b1) begin n_fail++; $display("FAIL rm_rready: got %b want 1", rready); end
    rst = 1'b1;
    tick(); // cycle 3
    rst = 1'b0;
    n_chk++; if ({arvalid, rready, awvalid, wvalid, bready, inst_ok, data_read_ok, data_write_ok} !== 8'd0) begin
      n_fail++; $display("FAIL rm_cleared: got %b want 00000000", {arvalid, rready, awvalid, wvalid, bready, inst_ok, data_read_ok, data_write_ok});
    end
    tick();
    inst_ren = 1'b1; inst_addr = 32'h1FC0_0300; arready = 1'b1;
    tick();
    inst_ren = 1'b0;
    n_chk++; if ({arvalid, araddr} !== {1'b1, 32'h1FC0_0300}) begin n_fail++; $display("FAIL rm_new_ar: got %h want 11fc00300", {arvalid, araddr}); end
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0BAD_F00D;
    tick();
    rvalid = 1'b0;
    n_chk++; if ({inst_ok, inst_rdata} !== {1'b1, 32'h0BAD_F00D}) begin n_fail++; $display("FAIL rm_new_ok: got %h want 10badf00d", {inst_ok, inst_rdata}); end
    tick();
  endtask

`ifdef MEM_AXI_BUS_ERR_EN
  task automatic test_bus_err();
    n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL be_initial: got %b want 0", bus_err); end
    data_wen = 4'hF; data_addr = 32'h1FAF_0000; data_wdata = 32'h5555_AAAA; awready = 1'b1; wready = 1'b1;
    tick(); // cycle 1
    tick(); // cycle 2
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b10;
    tick(); // cycle 3
    bvalid = 1'b0; bresp = 2'b00;
    n_chk++; if (data_write_ok !== 1'b1) begin n_fail++; $display("FAIL be_ok: got %b want 1", data_write_ok); end
    n_chk++; if ({bus_err, bus_err_addr} !== {1'b1, 32'h1FAF_0000}) begin n_fail++; $display("FAIL be_flag: got %h want 11faf0000", {bus_err, bus_err_addr}); end
    tick();
    data_wen = 4'h0;
    for (int c = 0; c < 5; c++) tick();
    n_chk++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL be_sticky: got %b want 1", bus_err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if ({bus_err, bus_err_addr} !== 33'd0) begin n_fail++; $display("FAIL be_clear: got %h want 0", {bus_err, bus_err_addr}); end
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1;
    inst_ren = 1'b0; inst_addr = 32'h0;
    data_ren = 1'b0; data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rid = '0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
    bid = '0; bresp = 2'b00; bvalid = 1'b0;
    #1;
    test_reset();
    test_inst_read();
    test_write_delayed_aw();
    test_priority();
    test_ar_stall();
    test_reset_mid();
`ifdef MEM_AXI_BUS_ERR_EN
    test_bus_err();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_axi_bridge.md
Name: mem_axi_bridge

Overview:
- Downstream of the CPU-side SRAM interface.
- Converts its single-word instruction-read, data-read and data-write requests into single-beat AXI transactions. Handles one outstanding transaction at a time.
- Returns one-cycle ok pulses carrying registered read data.
- Sits between the SRAM-style request port and the SoC AXI crossbar.

Parameters:
- ID_W, 4: width of the AXI arid/rid/awid/bid fields.
- INST_ID, 0: arid used for instruction reads.
- DATA_ID, 1: arid/awid used for data reads and writes.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- inst_ren  input  1  instruction read request, one-cycle pulse
- inst_addr  input  32  physical instruction address
- inst_ok  output  1  instruction read done, one-cycle pulse
- inst_rdata  output  32  instruction word, valid while inst_ok=1
- data_ren  input  1  data read request, one-cycle pulse
- data_wen  input  4  byte write enables; nonzero level is held until data_write_ok
- data_addr  input  32  physical data address
- data_wdata  input  32  write data
- data_read_ok  output  1  data read done, pulse
- data_write_ok  output  1  data write done, pulse
- data_rdata  output  32  data word, valid while data_read_ok=1
- arid/araddr/arvalid  output  ID_W/32/1  AXI read address channel
- arready  input  1  AXI read address ready
- rid/rdata/rresp/rlast/rvalid  input  ID_W/32/2/1/1  AXI read data channel
- rready  output  1  AXI read data ready
- awid/awaddr/awvalid  output  ID_W/32/1  AXI write address channel
- awready  input  1  AXI write address ready
- wid/wdata/wstrb/wlast/wvalid  output  ID_W/32/4/1/1  AXI write data channel
- wready  input  1  AXI write data ready
- bid/bresp/bvalid  input  ID_W/2/1  AXI write response channel
- bready  output  1  AXI write response ready
- arlen/awlen, arsize/awsize, arburst/awburst, arlock/awlock, arcache/awcache, arprot/awprot  output  8/3/2/2/4/3  constants: 0, 3'd2, 2'b01, 0, 0, 0

Behaviour:
- Reset (rst synchronous, active-high; clock clk):
  - State IDLE.
  - All valid/ready/ok outputs 0; all address, data and strobe registers 0; wlast constant 1.
- States: IDLE, RD_AR, RD_R, WR_AWW, WR_B, RESP.
- IDLE, request capture:
  - Priority is data write (data_wen!=0), then data_ren, then inst_ren.
  - Capture address, wdata, wstrb=data_wen and the source tag (INST/DREAD/DWRITE).
  - Read → RD_AR; write → WR_AWW.
- Losing pulses are not queued. The upstream block never issues inst_ren together with a data request, so no loss occurs.
- RD_AR:
  - arvalid=1; araddr and arid are stable until arready.
  - On arready → RD_R, with rready=1 from that next cycle.
- RD_R:
  - On rvalid & rready (rlast is always 1): latch rdata → RESP.
  - rid is ignored.
- WR_AWW:
  - awvalid=1 and wvalid=1 in the same cycle. Each drops independently after its own handshake.
  - When both handshakes have completed (same or different cycles) → WR_B, with bready=1.
- WR_B: on bvalid → RESP.
- RESP:
  - Exactly one cycle; pulse the ok matching the source tag. inst_rdata/data_rdata carry the latched word in that cycle.
  - Next state is IDLE.
  - Requests present in the RESP cycle are ignored. This is why the held data_wen, cleared by upstream on the write_ok edge, is never re-captured.
- Minimum latency, request cycle = 0:
  - arvalid in cycle 1.
  - rvalid earliest cycle 2.
  - ok in cycle 3.
  - Write path has the same latency, with bvalid earliest cycle 2.
- rresp/bresp are ignored in the base configuration.
- Requests arriving while not IDLE are ignored; upstream guarantees none occur.
- rst mid-transaction: return to IDLE immediately and drop all valids. The interconnect is reset together with the bridge.

Optional Feature:
- Macro: MEM_AXI_BUS_ERR_EN.
- Defined:
  - Adds output bus_err (1 bit) and output bus_err_addr (32 bits).
  - bus_err is sticky: it sets on any rresp or bresp of SLVERR or DECERR, and bus_err_addr captures the failing address.
  - Both clear only on rst.
  - The ok pulse is still issued.
- Undefined: ports absent; responses are not checked.

Decomposition:
- Shared package/defines holds:
  - state encodings;
  - AXI constants: BURST_INCR=2'b01, SIZE_WORD=3'd2, RESP_OKAY=2'b00;
  - source tag encoding;
  - INST_ID/DATA_ID defaults.
- No sub-module; a single FSM with channel-done flags.

Test Plan:
- inst_ren pulse, inst_addr=0x1FC00000, arready=1, rvalid 1 cycle later with rdata=0x3C08BFC0 → arid=0, araddr=0x1FC00000, inst_ok pulse of one cycle in cycle 3, inst_rdata=0x3C08BFC0.
- data_wen=4'b0011 held, addr=0x00001004, wdata=0xDEAD_BEEF; awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle, awvalid after 4; wstrb=0011; exactly one data_write_ok after bvalid; wen dropped the next cycle is not re-captured.
- data_ren and inst_ren in the same cycle → data read issued only, arid=1, data_read_ok with the returned word; no AXI read for inst.
- arready held low 10 cycles → arvalid and araddr stable throughout; no ok is issued until after R.
- rst asserted in RD_R → all valid/ready/ok are 0 the next cycle; a new inst_ren afterwards completes normally.
- With MEM_AXI_BUS_ERR_EN: bresp=2'b10 for addr 0x1FAF0000 → bus_err=1, bus_err_addr=0x1FAF0000, data_write_ok is still pulsed, and bus_err stays 1 until rst.
